// File: rtl/t07_mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package t07_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic [1:0] RWI_IDLE  = 2'b00;
  localparam logic [1:0] RWI_READ  = 2'b01;
  localparam logic [1:0] RWI_WRITE = 2'b10;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  localparam logic [3:0] RUN_CNT_SAT = 4'd15;

endpackage

// File: rtl/t07_busy_edge.sv
// Falling-edge detector for the external memory busy line.
module t07_busy_edge (
  input  logic clk,
  input  logic nrst,
  input  logic busy,
  output logic fall
);

  logic prev_busy_r;

  // Remember last cycle's busy level.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_busy_r <= 1'b0;
    end else begin
      prev_busy_r <= busy;
    end
  end

  assign fall = prev_busy_r & ~busy;

endmodule

// File: rtl/t07_mem_arbiter.sv
// Fetch/data arbiter in front of a single rwi/busy memory port; data has priority
// with a fetch starvation guard. Optional watchdog: T07_MEM_ARB_TIMEOUT_EN.
module t07_mem_arbiter
  import t07_mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic [1:0]        ext_rwi,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_busy,
  output logic              grant_id,
  output logic              arb_err
);

  localparam logic [3:0] RUN_LIMIT = 4'(MAX_DATA_RUN);

  arb_state_t        state_r, state_s;
  logic              busy_fall_s;
  logic              timeout_s;
  logic              any_req_s;
  logic              grant_data_s;
  logic [DATA_W-1:0] rd_val_s;
  logic [3:0]        run_cnt_r;
  logic [1:0]        cmd_r;
  logic [1:0]        ext_rwi_r;
  logic [ADDR_W-1:0] ext_addr_r;
  logic [DATA_W-1:0] ext_wdata_r;
  logic              grant_r;
  logic              fetch_ack_r, data_ack_r;
  logic [DATA_W-1:0] fetch_rdata_r, data_rdata_r;

  if (TIMEOUT_CYC < 1 || MAX_DATA_RUN < 1 || MAX_DATA_RUN > 15) begin : g_param_range
  end

  t07_busy_edge u_busy_edge (
    .clk  (clk),
    .nrst (nrst),
    .busy (ext_busy),
    .fall (busy_fall_s)
  );

  // Winner selection: data first unless fetch has waited through a full data run.
  always_comb begin
    any_req_s    = fetch_req | data_req;
    grant_data_s = data_req & ~(fetch_req & (run_cnt_r >= RUN_LIMIT));
    if (busy_fall_s) begin
      rd_val_s = ext_rdata;
    end else begin
      rd_val_s = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_s = ISSUE;
        else           state_s = IDLE;
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (busy_fall_s || timeout_s) state_s = DONE;
        else                          state_s = WAIT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register plus latched command, run counter, acks and read data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r       <= IDLE;
      run_cnt_r     <= 4'd0;
      cmd_r         <= RWI_IDLE;
      ext_rwi_r     <= RWI_IDLE;
      ext_addr_r    <= '0;
      ext_wdata_r   <= '0;
      grant_r       <= GRANT_FETCH;
      fetch_ack_r   <= 1'b0;
      data_ack_r    <= 1'b0;
      fetch_rdata_r <= '0;
      data_rdata_r  <= '0;
    end else begin
      state_r     <= state_s;
      ext_rwi_r   <= RWI_IDLE;
      fetch_ack_r <= 1'b0;
      data_ack_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s && grant_data_s) begin
            grant_r     <= GRANT_DATA;
            ext_addr_r  <= data_addr;
            ext_wdata_r <= data_we ? data_wdata : '0;
            cmd_r       <= data_we ? RWI_WRITE : RWI_READ;
            ext_rwi_r   <= data_we ? RWI_WRITE : RWI_READ;
            if (fetch_req) begin
              run_cnt_r <= (run_cnt_r == RUN_CNT_SAT) ? RUN_CNT_SAT : run_cnt_r + 4'd1;
            end else begin
              run_cnt_r <= 4'd0;
            end
          end else if (any_req_s) begin
            grant_r     <= GRANT_FETCH;
            ext_addr_r  <= fetch_addr;
            ext_wdata_r <= '0;
            cmd_r       <= RWI_READ;
            ext_rwi_r   <= RWI_READ;
            run_cnt_r   <= 4'd0;
          end
        end
        WAIT: begin
          // A watchdog expiry completes the transaction with zero read data.
          if (busy_fall_s || timeout_s) begin
            if (grant_r == GRANT_DATA) begin
              data_ack_r <= 1'b1;
              if (cmd_r == RWI_READ) data_rdata_r <= rd_val_s;
            end else begin
              fetch_ack_r   <= 1'b1;
              fetch_rdata_r <= rd_val_s;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef T07_MEM_ARB_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt_r;
  logic            arb_err_r;

  assign timeout_s = (state_r == WAIT) && (wd_cnt_r == WD_LAST);

  // Watchdog counts WAIT cycles; the error flag stays set until reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wd_cnt_r  <= '0;
      arb_err_r <= 1'b0;
    end else begin
      if (state_r == WAIT) wd_cnt_r <= wd_cnt_r + WD_W'(1);
      else                 wd_cnt_r <= '0;
      if (timeout_s && !busy_fall_s) arb_err_r <= 1'b1;
    end
  end

  assign arb_err = arb_err_r;
`else
  assign timeout_s = 1'b0;
  assign arb_err   = 1'b0;
`endif

  assign ext_rwi     = ext_rwi_r;
  assign ext_addr    = ext_addr_r;
  assign ext_wdata   = ext_wdata_r;
  assign grant_id    = grant_r;
  assign fetch_ack   = fetch_ack_r;
  assign data_ack    = data_ack_r;
  assign fetch_rdata = fetch_rdata_r;
  assign data_rdata  = data_rdata_r;

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// Directed plus randomized bench for t07_mem_arbiter; the random phases are checked
// against a transaction-level model of requesters and a latency-randomized memory.
`timescale 1ns/1ps
module tb_t07_mem_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0, ext_busy = 1'b0;
  logic [31:0] fetch_addr = 32'h0, data_addr = 32'h0, data_wdata = 32'h0, ext_rdata = 32'h0;
  logic        fetch_ack, data_ack, grant_id, arb_err;
  logic [31:0] fetch_rdata, data_rdata, ext_addr, ext_wdata;
  logic [1:0]  ext_rwi;

  t07_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .nrst(nrst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .ext_rwi(ext_rwi), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
    .ext_busy(ext_busy), .grant_id(grant_id), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Requester / memory model state for the random phases.
  bit          fp, dp, d_we, txn, own, rec, exp_gid;
  logic [31:0] f_addr, d_addr, d_wdata, exp_addr, exp_wd, mem_rd, exp_frd, exp_drd;
  logic [1:0]  exp_code;
  int          issue_cyc, ack_cyc, free_cyc, mem_start, mem_fall, streak;
  bit          grants_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rwi"}, ext_rwi, 0);
    chk({tag, "_addr"}, ext_addr, 0);
    chk({tag, "_wdata"}, ext_wdata, 0);
    chk({tag, "_fack"}, fetch_ack, 0);
    chk({tag, "_dack"}, data_ack, 0);
    chk({tag, "_frd"}, fetch_rdata, 0);
    chk({tag, "_drd"}, data_rdata, 0);
    chk({tag, "_gid"}, grant_id, 0);
    chk({tag, "_err"}, arb_err, 0);
  endtask

  task automatic run_traffic(input int n, input int pct);
    int k;
    k = 0; txn = 0; free_cyc = 0; issue_cyc = -1; ack_cyc = -1; mem_start = -1; mem_fall = -1;
    while ((k < n || txn || fp || dp) && k < n + 400) begin
      chk("rnd_rwi", ext_rwi, (k == issue_cyc) ? exp_code : 2'b00);
      if (k == issue_cyc) begin
        chk("rnd_addr", ext_addr, exp_addr);
        chk("rnd_wdata", ext_wdata, exp_wd);
        mem_start = k + int'($urandom_range(0, 2));
        mem_fall  = mem_start + int'($urandom_range(1, 3));
        mem_rd    = $urandom;
        ack_cyc   = mem_fall + 1;
      end
      if (k == ack_cyc && exp_code == 2'b01) begin
        if (own) exp_drd = mem_rd;
        else     exp_frd = mem_rd;
      end
      chk("rnd_gid", grant_id, exp_gid);
      chk("rnd_fack", fetch_ack, (k == ack_cyc) && !own);
      chk("rnd_dack", data_ack, (k == ack_cyc) && own);
      chk("rnd_frd", fetch_rdata, exp_frd);
      chk("rnd_drd", data_rdata, exp_drd);
      chk("rnd_err", arb_err, 0);
      ext_busy  = (k >= mem_start) && (k < mem_fall);
      ext_rdata = (k == mem_fall) ? mem_rd : $urandom;
      if (k == ack_cyc) begin
        if (own) dp = 0;
        else     fp = 0;
        txn = 0;
        free_cyc = k + 1;
      end
      if (!fp && k < n && int'($urandom_range(0, 99)) < pct) begin
        fp = 1; f_addr = $urandom;
      end
      if (!dp && k < n && int'($urandom_range(0, 99)) < pct) begin
        dp = 1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      fetch_req = fp; fetch_addr = f_addr;
      data_req = dp; data_we = d_we; data_addr = d_addr; data_wdata = d_wdata;
      if (!txn && k >= free_cyc && (fp || dp)) begin
        if (dp && !(fp && streak >= 4)) begin
          own = 1; exp_code = d_we ? 2'b10 : 2'b01; exp_addr = d_addr;
          exp_wd = d_we ? d_wdata : 32'h0;
          streak = fp ? streak + 1 : 0;
        end else begin
          own = 0; exp_code = 2'b01; exp_addr = f_addr; exp_wd = 32'h0; streak = 0;
        end
        exp_gid = own; txn = 1; issue_cyc = k + 1;
        if (rec) grants_q.push_back(own);
      end
      tick();
      k++;
    end
    chk("rnd_drained", {63'd0, (txn || fp || dp)}, 0);
  endtask

  initial begin
    #500000;
    $error("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int off;
    // Reset state
    repeat (3) tick();
    chk_zero("rst");
    nrst = 1'b1;
    tick();
    chk_zero("rst_rel");

    // 1: single fetch, busy high cycles 2-5
    fetch_req = 1; fetch_addr = 32'h100;
    chk("t1_rwi_c0", ext_rwi, 0);
    tick();
    chk("t1_rwi_c1", ext_rwi, 2'b01);
    chk("t1_addr", ext_addr, 32'h100);
    chk("t1_wdata", ext_wdata, 0);
    chk("t1_gid", grant_id, 0);
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk("t1_rwi_off", ext_rwi, 0);
      chk("t1_noack", fetch_ack, 0);
      ext_busy = (c <= 5);
      ext_rdata = (c == 6) ? 32'hDEADBEEF : 32'h0BAD0BAD;
    end
    tick();
    chk("t1_ack", fetch_ack, 1);
    chk("t1_rdata", fetch_rdata, 32'hDEADBEEF);
    chk("t1_gid_done", grant_id, 0);
    chk("t1_dack", data_ack, 0);
    fetch_req = 0;
    tick();
    chk("t1_ack_pulse", fetch_ack, 0);

    // 4: spurious fall in ISSUE is ignored
    data_req = 1; data_we = 0; data_addr = 32'h40; ext_busy = 1;
    tick();
    chk("t4_rwi", ext_rwi, 2'b01);
    ext_busy = 0; ext_rdata = 32'h11111111;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("t4_noack", data_ack, 0);
      ext_busy = (c < 4);
      ext_rdata = (c == 4) ? 32'hCAFEF00D : 32'h22222222;
    end
    tick();
    chk("t4_ack", data_ack, 1);
    chk("t4_rdata", data_rdata, 32'hCAFEF00D);
    data_req = 0;
    tick();
    chk("t4_ack_pulse", data_ack, 0);

    // 2: simultaneous requests, store wins, fetch follows
    fetch_req = 1; fetch_addr = 32'h300;
    data_req = 1; data_we = 1; data_addr = 32'h2000; data_wdata = 32'h55;
    tick();
    chk("t2_rwi", ext_rwi, 2'b10);
    chk("t2_addr", ext_addr, 32'h2000);
    chk("t2_wdata", ext_wdata, 32'h55);
    chk("t2_gid", grant_id, 1);
    ext_busy = 1;
    tick();
    ext_busy = 0; ext_rdata = 32'h33333333;
    chk("t2_noack", data_ack, 0);
    tick();
    chk("t2_dack", data_ack, 1);
    chk("t2_fack_loser", fetch_ack, 0);
    chk("t2_store_keeps_rdata", data_rdata, 32'hCAFEF00D);
    data_req = 0;
    tick();
    chk("t2_idle_rwi", ext_rwi, 0);
    tick();
    chk("t2_f_rwi", ext_rwi, 2'b01);
    chk("t2_f_addr", ext_addr, 32'h300);
    chk("t2_f_gid", grant_id, 0);
    ext_busy = 1;
    tick();
    ext_busy = 0; ext_rdata = 32'h12345678;
    tick();
    chk("t2_fack", fetch_ack, 1);
    chk("t2_frd", fetch_rdata, 32'h12345678);
    chk("t2_drd_held", data_rdata, 32'hCAFEF00D);
    fetch_req = 0;
    tick();

    // 5: reset mid-WAIT aborts silently
    fetch_req = 1; fetch_addr = 32'h500;
    tick();
    chk("t5_rwi", ext_rwi, 2'b01);
    ext_busy = 1;
    tick();
    nrst = 0;
    #1;
    chk_zero("t5_rst");
    fetch_req = 0; ext_busy = 0;
    tick();
    tick();
    nrst = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_noack_f", fetch_ack, 0);
      chk("t5_noack_d", data_ack, 0);
      chk("t5_rwi_idle", ext_rwi, 0);
    end
    data_req = 1; data_we = 1; data_addr = 32'h600; data_wdata = 32'hA5A5;
    tick();
    chk("t5_next_rwi", ext_rwi, 2'b10);
    chk("t5_next_addr", ext_addr, 32'h600);
    chk("t5_next_wdata", ext_wdata, 32'hA5A5);
    ext_busy = 1;
    tick();
    ext_busy = 0;
    tick();
    chk("t5_next_ack", data_ack, 1);
    chk("t5_next_drd", data_rdata, 0);
    data_req = 0;
    tick();

    // Random traffic, then continuous contention for the starvation guard
    fp = 0; dp = 0; d_we = 0; f_addr = 0; d_addr = 0; d_wdata = 0;
    exp_frd = 0; exp_drd = 0; exp_gid = 1; streak = 0; rec = 0; own = 1; exp_code = 2'b10;
    run_traffic(600, 35);
    grants_q.delete();
    rec = 1;
    run_traffic(120, 100);
    chk("t3_grant_count", {63'd0, grants_q.size() >= 10}, 1);
    for (int i = 0; i < 10; i++) begin
      if (i < grants_q.size()) chk("t3_grant_seq", grants_q[i], (i == 4 || i == 9) ? 1'b0 : 1'b1);
    end

`ifdef T07_MEM_ARB_TIMEOUT_EN
    // 6: watchdog expiry with busy stuck high
    data_req = 1; data_we = 0; data_addr = 32'h700; ext_busy = 0;
    tick();
    chk("t6_rwi", ext_rwi, 2'b01);
    ext_busy = 1;
    off = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (off < 0 && data_ack) begin
        off = c;
        data_req = 0;
        chk("t6_drd_zero", data_rdata, 0);
        chk("t6_err_set", arb_err, 1);
      end
    end
    chk("t6_ack_latency", {63'd0, (off >= 9 && off <= 10)}, 1);
    ext_busy = 0;
    repeat (3) tick();
    chk("t6_err_sticky", arb_err, 1);
    chk("t6_no_extra_ack", data_ack, 0);
`else
    off = 0;
    chk("t6_err_tied", arb_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/t07_mem_arbiter.md
Name: t07_mem_arbiter

Overview:
Two-port arbiter between the CPU instruction-fetch port and the load/store data port, in front of the single external memory interface (rwi/busy handshake).
- Latches one request at a time and drives the bus command.
- Detects completion by the falling edge of ext_busy.
- Returns read data with a one-cycle ack.
- Data has fixed priority over fetch, with a starvation guard so fetch always makes progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_DATA_RUN, 4, maximum consecutive data grants while fetch is pending before fetch is forced (1..15)
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request; held with fetch_addr stable until fetch_ack
fetch_addr  in  ADDR_W  fetch address
fetch_ack  out  1  one-cycle pulse: fetch complete, fetch_rdata valid
fetch_rdata  out  DATA_W  fetched instruction, registered, held until next fetch ack
data_req  in  1  load/store request; held stable until data_ack
data_we  in  1  1 = store, 0 = load
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_ack  out  1  one-cycle pulse: load/store complete
data_rdata  out  DATA_W  load data, registered, held until next data ack
ext_rwi  out  2  00 idle, 01 read, 10 write; nonzero for exactly one cycle per transaction
ext_addr  out  ADDR_W  latched address, held for the whole transaction
ext_wdata  out  DATA_W  latched write data (0 for reads)
ext_rdata  in  DATA_W  memory read data, valid on the cycle busy falls
ext_busy  in  1  memory busy
grant_id  out  1  0 = fetch, 1 = data; owner of the current or last transaction
arb_err  out  1  sticky timeout flag (0 unless the optional feature is compiled in)

Behaviour:
- Reset: state IDLE; all outputs 0; run counter 0; previous-busy register 0. Asserting reset mid-transaction aborts it silently, with no ack.
- Edge: busy_fall = prev_busy & ~ext_busy. prev_busy is registered every cycle.
- IDLE:
  - Neither request: stay.
  - Otherwise pick a winner: data if data_req and NOT (fetch_req and run_cnt >= MAX_DATA_RUN); else fetch.
  - Latch addr, wdata (0 for loads/fetch), rwi code and grant_id.
  - Go to ISSUE.
- ISSUE: ext_rwi = latched code for one cycle; go to WAIT.
- WAIT:
  - ext_rwi = 00; addr/wdata held.
  - On busy_fall: capture ext_rdata into the owner's rdata register (reads only) and go to DONE.
  - A busy_fall in the ISSUE cycle is ignored. Only edges seen in WAIT count.
- DONE: pulse the owner's ack for one cycle; go to IDLE.
- Run counter:
  - Data grant while fetch_req is high: increment, saturating at 15.
  - Any fetch grant: clear to 0.
  - Data grant with fetch_req low: clear to 0.
- Minimum latency: req seen in IDLE at cycle 0, ext_rwi at cycle 1, earliest ack at cycle 4 (busy rises at 2, falls at 3).
- Next transaction arbitration resumes in the cycle after the ack, in IDLE.
- Requester drops req mid-transaction: the transaction completes and the ack still pulses; requesters must tolerate this.
- Both requests arriving in the same cycle: decided by the priority rule above. The loser's req stays pending, with no ack.
- Store completion: data_rdata is unchanged.

Optional Feature:
T07_MEM_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT.
  - Reaching TIMEOUT_CYC forces DONE with rdata = 0 and sets arb_err, which is sticky until reset. The owner's ack still pulses.
- Undefined: no counter; arb_err is tied 0; WAIT waits forever.

Decomposition:
Package t07_mem_arb_pkg holds:
- arb_state_t enum: IDLE, ISSUE, WAIT, DONE.
- RWI_IDLE/RWI_READ/RWI_WRITE 2-bit constants.
- GRANT_FETCH/GRANT_DATA constants.

Sub-module t07_busy_edge (registered falling-edge detector, clk/nrst/busy in, fall out) is instantiated once.

Test Plan:
1. Fetch only:
   - Stimulus: fetch_req=1, addr 0x100; ext_busy high for cycles 2-5; ext_rdata=0xDEADBEEF at fall.
   - Response: ext_rwi=01 at cycle 1 only; fetch_ack at cycle 7; fetch_rdata=0xDEADBEEF; grant_id=0.
2. Simultaneous requests:
   - Stimulus: fetch_req and data_req (we=1, addr 0x2000, wdata 0x55) in the same cycle.
   - Response: ext_rwi=10, ext_addr=0x2000, ext_wdata=0x55; data_ack first, then the fetch transaction follows.
3. Starvation:
   - Stimulus: data_req held continuously and fetch_req held, MAX_DATA_RUN=4.
   - Response: exactly 4 data acks, then one fetch ack, then data resumes.
4. Spurious edge:
   - Stimulus: busy falls in the ISSUE cycle, rises again, falls 3 cycles later.
   - Response: ack only after the second fall.
5. Reset mid-WAIT:
   - Stimulus: nrst low during WAIT.
   - Response: all outputs 0 immediately; no ack after release; the next request is served normally.
6. Timeout (macro defined, TIMEOUT_CYC=8):
   - Stimulus: busy never falls.
   - Response: data_ack 9-10 cycles after ISSUE, data_rdata=0, arb_err=1 and held.
